// File: rtl/sp_fifo_ctrl.sv
// sp_fifo_ctrl: valid/ready FIFO front-end for a single-port RAM with 1-cycle read latency.
// Optional feature macro SP_FIFO_STATUS_EN adds the level and overflow_err status outputs.
module sp_fifo_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_SIZE   = 1024,
    parameter int ADDR_WIDTH = (MEM_SIZE == 1) ? 1 : $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_enable_write,
    output logic                  ram_ctrl_write,
    output logic                  ram_enable_read,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_write,
    input  logic [DATA_WIDTH-1:0] ram_data_read
`ifdef SP_FIFO_STATUS_EN
    ,
    output logic [$clog2(MEM_SIZE+3)-1:0] level,
    output logic                          overflow_err
`endif
);

    localparam int                    CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [0:0]            PRIO_WR   = 1'b0;
    localparam logic [0:0]            PRIO_RD   = 1'b1;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_mem_cnt;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_ob0;
    logic [DATA_WIDTH-1:0] r_ob1;
    logic [1:0]            r_ob_cnt;
    logic [0:0]            r_prio;

    logic                  w_wr_ok;
    logic                  w_rd_req;
    logic                  w_in_ready;
    logic                  w_rd_gnt;
    logic                  w_wr_gnt;
    logic                  w_contend;
    logic                  w_pop;
    logic [1:0]            w_ob_cnt_pop;
    logic [1:0]            w_ob_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_ob0_nxt;
    logic [DATA_WIDTH-1:0] w_ob1_nxt;

    // Reads are only issued when the output buffer is guaranteed room for the returning word.
    always_comb begin
        w_wr_ok    = (r_mem_cnt != FULL_CNT);
        w_rd_req   = (r_mem_cnt != '0) &&
                     (({1'b0, r_ob_cnt} + {2'b00, r_inflight}) < 3'd2);
        w_in_ready = !rst && w_wr_ok && !(w_rd_req && (r_prio == PRIO_RD));
        w_rd_gnt   = !rst && w_rd_req && ((r_prio == PRIO_RD) || !(in_valid && w_wr_ok));
        w_wr_gnt   = in_valid && w_in_ready;
        w_contend  = w_rd_req && in_valid && w_wr_ok;
    end

    always_comb begin
        w_pop        = (r_ob_cnt != 2'd0) && out_ready;
        w_ob_cnt_pop = r_ob_cnt - {1'b0, w_pop};
        w_ob0_nxt    = w_pop ? r_ob1 : r_ob0;
        w_ob1_nxt    = r_ob1;
        if (r_inflight) begin
            if (w_ob_cnt_pop == 2'd0) begin
                w_ob0_nxt = ram_data_read;
            end else begin
                w_ob1_nxt = ram_data_read;
            end
        end
        w_ob_cnt_nxt = w_ob_cnt_pop + {1'b0, r_inflight};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
            r_ob0      <= '0;
            r_ob1      <= '0;
            r_ob_cnt   <= 2'd0;
            r_prio     <= PRIO_WR;
        end else begin
            if (w_wr_gnt) begin
                r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_gnt) begin
                r_rd_ptr <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_wr_gnt, w_rd_gnt})
                2'b10:   r_mem_cnt <= r_mem_cnt + CNT_W'(1);
                2'b01:   r_mem_cnt <= r_mem_cnt - CNT_W'(1);
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            r_inflight <= w_rd_gnt;
            r_ob0      <= w_ob0_nxt;
            r_ob1      <= w_ob1_nxt;
            r_ob_cnt   <= w_ob_cnt_nxt;
            if (w_contend) begin
                r_prio <= ~r_prio;
            end
        end
    end

    assign in_ready         = w_in_ready;
    assign out_valid        = (r_ob_cnt != 2'd0);
    assign out_data         = r_ob0;
    assign ram_enable_write = w_wr_gnt;
    assign ram_ctrl_write   = w_wr_gnt;
    assign ram_enable_read  = w_rd_gnt;
    assign ram_addr         = w_wr_gnt ? r_wr_ptr : (w_rd_gnt ? r_rd_ptr : '0);
    assign ram_data_write   = rst ? '0 : in_data;

`ifdef SP_FIFO_STATUS_EN
    localparam int LVL_W = $clog2(MEM_SIZE + 3);

    logic [LVL_W-1:0] r_level;
    logic             r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_level <= LVL_W'(r_mem_cnt) + LVL_W'(r_inflight) + LVL_W'(r_ob_cnt);
            if (in_valid && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign level        = r_level;
    assign overflow_err = r_overflow;
`endif

endmodule
